// File: rtl/uart_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_pkg
// Shared constants and types for the UART transmit FIFO slice.
//   FIFO_DEPTH : capacity of the transmit FIFO in bytes
//   LOAD_W     : width of the FIFO occupancy (s_load) bus
//   BYTE_W     : width of one FIFO data word
//   arb_state_t: write-port arbiter FSM states
// ---------------------------------------------------------------------------
package uart_fifo_pkg;

    localparam int FIFO_DEPTH = 64;
    localparam int LOAD_W     = 7;
    localparam int BYTE_W     = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker. The search starts one position
// above rr_ptr and wraps modulo N_REQ, so the last owner has lowest priority.
//   eligible     in  N_REQ  requesters allowed to win this arbitration
//   rr_ptr       in  IDW    index of the previous owner
//   grant_onehot out N_REQ  winner as a one-hot vector (all zero if none)
//   grant_idx    out IDW    winner index (0 if none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = 3
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDW-1:0]   grant_idx
);

    logic found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && eligible[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                grant_onehot[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
                grant_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// uart_fifo_write_arbiter
// Shares the UART transmit FIFO write port between N_REQ byte producers.
// Round-robin arbitration with burst locking; low-priority requesters are
// held off in IDLE while the FIFO is within RESERVE slots of full.
//
// Handshake: every byte interface is valid/ready. A byte moves on a cycle
// where valid and ready are both high; valid never waits for ready, and the
// producer holds data/last stable until the byte is accepted.
//
//   s_clk      in  1        clock
//   s_rst      in  1        synchronous active-high reset
//   req_valid  in  N_REQ    per-requester byte valid
//   req_data   in  8*N_REQ  per-requester byte, requester i at [8i+7:8i]
//   req_last   in  N_REQ    final byte of a burst
//   req_ready  out N_REQ    per-requester accept
//   fifo_valid out 1        FIFO s_valid
//   fifo_ready in  1        FIFO s_ready
//   fifo_data  out 8        FIFO s_data
//   fifo_load  in  7        FIFO occupancy
//   grant_id   out IDW      current/last owner
//   busy       out 1        grant held
// ---------------------------------------------------------------------------
module uart_fifo_write_arbiter
    import uart_fifo_pkg::*;
#(
    parameter int               N_REQ      = 2,
    parameter int               IDW        = 3,
    parameter int               DEPTH      = FIFO_DEPTH,
    parameter int               RESERVE    = 8,
    parameter logic [N_REQ-1:0] HIPRI_MASK = 'b01,
    parameter int               MAX_BURST  = 16,
    parameter int               TIMEOUT    = 32
) (
    input  logic                      s_clk,
    input  logic                      s_rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_valid,
    input  logic                      fifo_ready,
    output logic [BYTE_W-1:0]         fifo_data,
    input  logic [LOAD_W-1:0]         fifo_load,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy
);

    localparam int                BEAT_W    = $clog2(MAX_BURST + 1);
    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [LOAD_W-1:0] THR_LEVEL = LOAD_W'(DEPTH - RESERVE);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    grant_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [BEAT_W-1:0] beats_q;
    logic [IDLE_W-1:0] idle_cnt_q;

    logic              thr;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDW-1:0]    pick_idx;
    logic              win;

    logic              g_valid;
    logic              g_last;
    logic [BYTE_W-1:0] g_data;
    logic              in_grant;
    logic              hs;
    logic              release_grant;

    // Throttle only gates new grants; an owner keeps its grant regardless.
    assign thr = (fifo_load >= THR_LEVEL);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] & (HIPRI_MASK[i] | ~thr);
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .eligible     (eligible),
        .rr_ptr       (rr_ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

    assign win = |pick_onehot;

    // Select the owner's lanes.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign in_grant = (state_q == ARB_GRANT);
    assign hs       = in_grant & g_valid & fifo_ready;

    // Last byte and burst limit on the same handshake are one release.
    assign release_grant = (hs & (g_last | (beats_q == BEAT_W'(MAX_BURST - 1))))
                         | (in_grant & ~g_valid & (idle_cnt_q == IDLE_W'(TIMEOUT - 1)));

    // State register
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (win)           state_d = ARB_GRANT;
            ARB_GRANT: if (release_grant) state_d = ARB_IDLE;
            default:                      state_d = ARB_IDLE;
        endcase
    end

    // Grant bookkeeping and counters
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            grant_q    <= '0;
            rr_ptr_q   <= IDW'(N_REQ - 1);
            beats_q    <= '0;
            idle_cnt_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (win) begin
                grant_q    <= pick_idx;
                beats_q    <= '0;
                idle_cnt_q <= '0;
            end
        end else begin
            if (release_grant) begin
                rr_ptr_q   <= grant_q;
                beats_q    <= '0;
                idle_cnt_q <= '0;
            end else if (hs) begin
                beats_q    <= beats_q + 1'b1;
                idle_cnt_q <= '0;
            end else if (!g_valid) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            // valid but stalled by fifo_ready: counters hold
        end
    end

    // Outputs; forced quiet during reset so a byte cannot slip through.
    always_comb begin
        fifo_valid = 1'b0;
        fifo_data  = '0;
        req_ready  = '0;
        if (in_grant && !s_rst) begin
            fifo_valid = g_valid;
            fifo_data  = g_data;
            for (int i = 0; i < N_REQ; i++) begin
                req_ready[i] = fifo_ready & (grant_q == IDW'(i));
            end
        end
    end

    assign busy     = in_grant & ~s_rst;
    assign grant_id = s_rst ? '0 : grant_q;

endmodule

// File: tb/tb_uart_fifo_write_arbiter.sv
module tb_uart_fifo_write_arbiter;

  logic        s_clk;
  logic        s_rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [7:0]  fifo_data;
  logic [6:0]  fifo_load;
  logic [2:0]  grant_id;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] lst;
    logic       fr;
    logic [6:0] ld;
    logic [1:0] e_ready;
    logic       e_fv;
    logic [7:0] e_fd;
    logic [2:0] e_gid;
    logic       e_busy;
  } vec_t;

  vec_t vq[$];

  uart_fifo_write_arbiter #(
    .N_REQ (2),
    .IDW   (3)
  ) dut (
    .s_clk      (s_clk),
    .s_rst      (s_rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready),
    .fifo_data  (fifo_data),
    .fifo_load  (fifo_load),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // clock / reset
  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  function automatic vec_t mk(input logic rst, input logic [1:0] rv,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] lst, input logic fr, input logic [6:0] ld,
                              input logic [1:0] er, input logic ef, input logic [7:0] ed,
                              input logic [2:0] eg, input logic eb);
    vec_t v;
    v.rst = rst; v.rv = rv; v.d0 = d0; v.d1 = d1; v.lst = lst; v.fr = fr; v.ld = ld;
    v.e_ready = er; v.e_fv = ef; v.e_fd = ed; v.e_gid = eg; v.e_busy = eb;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic rst, input logic [1:0] rv, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] lst, input logic fr,
                       input logic [6:0] ld);
    s_rst      = rst;
    req_valid  = rv;
    req_data   = {d1, d0};
    req_last   = lst;
    fifo_ready = fr;
    fifo_load  = ld;
  endtask

  task automatic end_cycle();
    @(posedge s_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fifo_valid", 32'(fifo_valid), 32'd0);
    end_cycle();
  endtask

  initial begin
    drive(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 7'd0);
    repeat (2) @(posedge s_clk);
    #1;

    // ------------------------------------------------------------------
    // Vector table: one record per cycle, inputs then expected outputs
    //               rst   rv     d0     d1     last   fr    load    ready  fv    fd     gid   busy
    // single requester, 3 bytes
    vq.push_back(mk(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    vq.push_back(mk(1'b0, 2'b01, 8'hA1, 8'h00, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    vq.push_back(mk(1'b0, 2'b01, 8'hA1, 8'h00, 2'b00, 1'b1, 7'd0,  2'b01, 1'b1, 8'hA1, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b01, 8'hA2, 8'h00, 2'b00, 1'b1, 7'd0,  2'b01, 1'b1, 8'hA2, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b01, 8'hA3, 8'h00, 2'b01, 1'b1, 7'd0,  2'b01, 1'b1, 8'hA3, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    // round robin, 2-byte bursts: 0,1,0,1 with a bubble between grants
    vq.push_back(mk(1'b1, 2'b11, 8'hB0, 8'hC0, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 8'hB0, 8'hC0, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 8'hB0, 8'hC0, 2'b00, 1'b1, 7'd0,  2'b01, 1'b1, 8'hB0, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB1, 8'hC0, 2'b01, 1'b1, 7'd0,  2'b01, 1'b1, 8'hB1, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB2, 8'hC0, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 8'hB2, 8'hC0, 2'b00, 1'b1, 7'd0,  2'b10, 1'b1, 8'hC0, 3'd1, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB2, 8'hC1, 2'b10, 1'b1, 7'd0,  2'b10, 1'b1, 8'hC1, 3'd1, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB2, 8'hC2, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd1, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 8'hB2, 8'hC2, 2'b00, 1'b1, 7'd0,  2'b01, 1'b1, 8'hB2, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB3, 8'hC2, 2'b01, 1'b1, 7'd0,  2'b01, 1'b1, 8'hB3, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB4, 8'hC2, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    // last of the non-granted requester 0 must not end requester 1's burst
    vq.push_back(mk(1'b0, 2'b11, 8'hB4, 8'hC2, 2'b01, 1'b1, 7'd0,  2'b10, 1'b1, 8'hC2, 3'd1, 1'b1));
    vq.push_back(mk(1'b0, 2'b11, 8'hB4, 8'hC3, 2'b11, 1'b1, 7'd0,  2'b10, 1'b1, 8'hC3, 3'd1, 1'b1));
    // throttle at load 56: low-priority requester 1 stays out
    vq.push_back(mk(1'b0, 2'b10, 8'h00, 8'hD0, 2'b10, 1'b1, 7'd56, 2'b00, 1'b0, 8'h00, 3'd1, 1'b0));
    vq.push_back(mk(1'b0, 2'b10, 8'h00, 8'hD0, 2'b10, 1'b1, 7'd56, 2'b00, 1'b0, 8'h00, 3'd1, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 8'hE0, 8'hD0, 2'b11, 1'b1, 7'd56, 2'b00, 1'b0, 8'h00, 3'd1, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 8'hE0, 8'hD0, 2'b11, 1'b1, 7'd56, 2'b01, 1'b1, 8'hE0, 3'd0, 1'b1));
    vq.push_back(mk(1'b0, 2'b10, 8'h00, 8'hD0, 2'b10, 1'b1, 7'd56, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    vq.push_back(mk(1'b0, 2'b10, 8'h00, 8'hD0, 2'b10, 1'b1, 7'd55, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0));
    // held grant survives load rising past the threshold
    vq.push_back(mk(1'b0, 2'b10, 8'h00, 8'hD0, 2'b10, 1'b1, 7'd60, 2'b10, 1'b1, 8'hD0, 3'd1, 1'b1));
    vq.push_back(mk(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 7'd0,  2'b00, 1'b0, 8'h00, 3'd1, 1'b0));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].rv, vq[i].d0, vq[i].d1, vq[i].lst, vq[i].fr, vq[i].ld);
      @(negedge s_clk);
      chk($sformatf("v%0d req_ready", i),  32'(req_ready),  32'(vq[i].e_ready));
      chk($sformatf("v%0d fifo_valid", i), 32'(fifo_valid), 32'(vq[i].e_fv));
      chk($sformatf("v%0d fifo_data", i),  32'(fifo_data),  32'(vq[i].e_fd));
      chk($sformatf("v%0d grant_id", i),   32'(grant_id),   32'(vq[i].e_gid));
      chk($sformatf("v%0d busy", i),       32'(busy),       32'(vq[i].e_busy));
      end_cycle();
    end

    // ------------------------------------------------------------------
    // MAX_BURST: req1 streams 20 bytes without last, req0 joins mid-burst
    do_reset();
    drive(1'b0, 2'b10, 8'h55, 8'd1, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("mb idle busy", 32'(busy), 32'd0);
    end_cycle();
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, (k >= 10) ? 2'b11 : 2'b10, 8'h55, 8'(k), 2'b01, 1'b1, 7'd0);
      @(negedge s_clk);
      chk($sformatf("mb byte%0d data", k), 32'(fifo_data), 32'(k));
      chk($sformatf("mb byte%0d ready", k), 32'(req_ready), 32'd2);
      chk($sformatf("mb byte%0d busy", k), 32'(busy), 32'd1);
      end_cycle();
    end
    drive(1'b0, 2'b11, 8'h55, 8'd17, 2'b01, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("mb forced release busy", 32'(busy), 32'd0);
    chk("mb forced release fv", 32'(fifo_valid), 32'd0);
    end_cycle();
    @(negedge s_clk);
    chk("mb req0 served gid", 32'(grant_id), 32'd0);
    chk("mb req0 served data", 32'(fifo_data), 32'h55);
    chk("mb req0 served ready", 32'(req_ready), 32'd1);
    end_cycle();
    drive(1'b0, 2'b10, 8'h00, 8'd17, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("mb bubble busy", 32'(busy), 32'd0);
    end_cycle();
    for (int k = 17; k <= 20; k++) begin
      drive(1'b0, 2'b10, 8'h00, 8'(k), (k == 20) ? 2'b10 : 2'b00, 1'b1, 7'd0);
      @(negedge s_clk);
      chk($sformatf("mb byte%0d data", k), 32'(fifo_data), 32'(k));
      chk($sformatf("mb byte%0d gid", k), 32'(grant_id), 32'd1);
      end_cycle();
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("mb end busy", 32'(busy), 32'd0);
    end_cycle();

    // ------------------------------------------------------------------
    // Back-pressure then timeout
    do_reset();
    drive(1'b0, 2'b01, 8'h61, 8'h00, 2'b00, 1'b1, 7'd0);
    end_cycle();
    @(negedge s_clk);
    chk("bp first data", 32'(fifo_data), 32'h61);
    end_cycle();
    for (int s = 0; s < 10; s++) begin
      drive(1'b0, 2'b01, 8'h62, 8'h00, 2'b00, 1'b0, 7'd0);
      @(negedge s_clk);
      chk($sformatf("bp stall%0d data", s), 32'(fifo_data), 32'h62);
      chk($sformatf("bp stall%0d ready", s), 32'(req_ready), 32'd0);
      chk($sformatf("bp stall%0d busy", s), 32'(busy), 32'd1);
      end_cycle();
    end
    drive(1'b0, 2'b01, 8'h62, 8'h00, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("bp resume ready", 32'(req_ready), 32'd1);
    end_cycle();
    for (int c = 1; c <= 32; c++) begin
      drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 7'd0);
      @(negedge s_clk);
      chk($sformatf("to idle%0d busy", c), 32'(busy), 32'd1);
      end_cycle();
    end
    @(negedge s_clk);
    chk("to released busy", 32'(busy), 32'd0);
    end_cycle();

    // ------------------------------------------------------------------
    // Reset mid-burst; a single-byte burst first moves rr_ptr to 0
    do_reset();
    drive(1'b0, 2'b01, 8'h70, 8'h00, 2'b01, 1'b1, 7'd0);
    end_cycle();
    @(negedge s_clk);
    chk("rm pre data", 32'(fifo_data), 32'h70);
    end_cycle();
    drive(1'b0, 2'b01, 8'h71, 8'h00, 2'b00, 1'b1, 7'd0);
    end_cycle();
    @(negedge s_clk);
    chk("rm byte1 data", 32'(fifo_data), 32'h71);
    end_cycle();
    drive(1'b1, 2'b11, 8'h72, 8'h81, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("rm in-reset ready", 32'(req_ready), 32'd0);
    chk("rm in-reset fv", 32'(fifo_valid), 32'd0);
    end_cycle();
    drive(1'b0, 2'b11, 8'h72, 8'h81, 2'b00, 1'b1, 7'd0);
    @(negedge s_clk);
    chk("rm after busy", 32'(busy), 32'd0);
    chk("rm after fv", 32'(fifo_valid), 32'd0);
    end_cycle();
    @(negedge s_clk);
    chk("rm first winner gid", 32'(grant_id), 32'd0);
    chk("rm first winner data", 32'(fifo_data), 32'h72);
    chk("rm first winner busy", 32'(busy), 32'd1);
    end_cycle();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_fifo_write_arbiter.md
Name: uart_fifo_write_arbiter

Overview:
- Shares the single write port (s_valid/s_ready/s_data, occupancy s_load) of the UART transmit FIFO between N_REQ byte producers, e.g. the CPU MMIO path and the debug monitor.
- Arbitration is round-robin with burst locking. A low-priority requester is throttled when the FIFO nears full, so a reserve of slots stays free for high-priority requesters.
- Sits in the FIFO write-clock domain, between the requesters and the FIFO.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- IDW, 3, width of grant_id; must satisfy 2**IDW >= N_REQ.
- DEPTH, 64, FIFO capacity in bytes; the full value fits in the 7-bit load.
- RESERVE, 8, slots kept free for high-priority requesters.
- HIPRI_MASK, 'b01, bit i set marks requester i as high priority.
- MAX_BURST, 16, maximum bytes per grant before a forced release.
- TIMEOUT, 32, idle cycles inside a grant before a forced release.

Ports:
- s_clk  in  1  clock; the single clock for the block.
- s_rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  marks the final byte of a requester's burst.
- req_ready  out  N_REQ  per-requester accept.
- fifo_valid  out  1  drives the FIFO s_valid.
- fifo_ready  in  1  from the FIFO s_ready.
- fifo_data  out  8  drives the FIFO s_data.
- fifo_load  in  7  FIFO occupancy, from s_load.
- grant_id  out  IDW  index of the current owner.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset, synchronous: all outputs and internal state clear in the same cycle.
  - State goes to IDLE; fifo_valid=0, req_ready=0, fifo_data=0, grant_id=0, busy=0.
  - rr_ptr=N_REQ-1, so requester 0 wins the first arbitration. Beat and timeout counters clear.
- Throttle: thr = (fifo_load >= DEPTH-RESERVE).
  - eligible[i] = req_valid[i] & (HIPRI_MASK[i] | ~thr).
  - Throttling is evaluated only in IDLE. A held grant is never revoked by thr.
- IDLE:
  - If eligible != 0, pick the first set bit searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - Register grant_id, set busy=1, clear the beat counter (beats) and the timeout counter (idle_cnt), and go to GRANT.
  - Outputs in IDLE: fifo_valid=0, req_ready=0.
  - Latency: a request that is valid in cycle t is granted at edge t+1. Its first byte can transfer in cycle t+1.
- GRANT, g = grant_id:
  - Combinational forwarding: fifo_valid=req_valid[g]; fifo_data=req_data[g]; req_ready[g]=fifo_ready; req_ready of every other requester = 0.
  - A handshake (hs) is req_valid[g] & fifo_ready.
  - On hs: beats++ and idle_cnt clears. If req_valid[g]=0: idle_cnt++.
  - Release to IDLE at the edge where any of these holds:
    - (a) hs & req_last[g];
    - (b) hs & beats==MAX_BURST-1;
    - (c) idle_cnt==TIMEOUT-1 & ~req_valid[g].
  - On release: rr_ptr=g, busy=0.
  - There is always one IDLE bubble cycle between grants.
- Back-pressure: fifo_ready=0 (FIFO full) stalls the burst without changing counters. A stall while req_valid[g]=1 does not count toward the timeout.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - (a) and (b) together count as a single release.
- The req_last of a non-granted requester is ignored.
- Reset asserted mid-burst: the grant is dropped immediately. A byte presented in that cycle is not accepted, because req_ready=0 during reset.
- Data ordering is preserved per requester. No byte is duplicated or dropped.

Decomposition:
- Shared package uart_fifo_pkg holds: FIFO_DEPTH=64, LOAD_W=7, BYTE_W=8, and the state enum {ARB_IDLE, ARB_GRANT}.
- One natural sub-module: rr_arbiter. It is a combinational round-robin priority picker with inputs (eligible, rr_ptr) and outputs (grant_onehot, grant_idx).
- Counters, the FSM and the muxing stay in the top module.

Test Plan:
- Single requester: req0 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3), fifo_ready=1 → granted one cycle after valid; fifo_data shows A1/A2/A3 on consecutive cycles; busy falls after A3; grant_id=0.
- Round-robin: both requesters continuously valid with 2-byte bursts → grant sequence 0, 1, 0, 1 with one IDLE bubble between grants; no byte is interleaved inside a burst.
- Throttle: fifo_load=56, HIPRI_MASK='b01, both valid → req0 is granted and req1 is never granted while load ≥56; after load drops to 55, req1 is granted after req0 releases.
- MAX_BURST: req1 streams 20 bytes without last → release after byte 16; req1 is re-granted only after req0 (if valid) has been served; bytes 17-20 then follow in order.
- Back-pressure and timeout: fifo_ready=0 for 10 cycles mid-burst → no release and the data is held; then req_valid[g]=0 for 32 cycles → busy falls at cycle 32.
- Reset mid-burst: assert s_rst during byte 2 of a 4-byte burst → the next cycle shows busy=0 and fifo_valid=0; after reset, requester 0 wins the first arbitration.
